// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: angle constants, CORDIC gain, atan table and FSM state type.
// Used by both the rotation-mode sin/cos block and the vectoring-mode atan block.
package cordic_pkg;

  localparam int K_GAIN     = 9949;   // 0.607253 in Q2.14
  localparam int PI         = 25736;  // Q3.13
  localparam int PI_HALF    = 12868;  // Q3.13
  localparam int ATAN_DEPTH = 14;
  localparam int ATAN_W     = 13;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROTATE,
    ST_DONE
  } cordic_state_t;

  // round(atan(2^-i) * 8192); indices past the table depth return 0
  function automatic logic [ATAN_W-1:0] atan_lut(input logic [3:0] idx);
    logic [ATAN_W-1:0] v;
    case (idx)
      4'd0:    v = 13'd6434;
      4'd1:    v = 13'd3798;
      4'd2:    v = 13'd2007;
      4'd3:    v = 13'd1019;
      4'd4:    v = 13'd511;
      4'd5:    v = 13'd256;
      4'd6:    v = 13'd128;
      4'd7:    v = 13'd64;
      4'd8:    v = 13'd32;
      4'd9:    v = 13'd16;
      4'd10:   v = 13'd8;
      4'd11:   v = 13'd4;
      4'd12:   v = 13'd2;
      4'd13:   v = 13'd1;
      default: v = 13'd0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational micro-rotation angle lookup: iteration index -> atan(2^-i) in Q3.13.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [3:0]        idx,
  output logic [ATAN_W-1:0] atan
);

  always_comb begin
    atan = atan_lut(idx);
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative rotation-mode CORDIC: angle (Q3.13) -> cos/sin (Q2.14), one micro-rotation per clock.
// Build option CORDIC_QUAD_EN: accept [-pi,pi] by folding into [-pi/2,pi/2]; otherwise clamp to +/-pi/2.
//
// state     | meaning
// ST_IDLE   | in_ready=1, waiting for an angle
// ST_ROTATE | micro-rotations 0..ITERATIONS-1, then result formatting
// ST_DONE   | out_valid=1, result held until out_ready
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 14,
  parameter int WIDTH      = 16,
  parameter int GUARD      = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] angle_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] cos_out,
  output logic [WIDTH-1:0] sin_out,
  output logic             out_oor
);

  localparam int XW = WIDTH + GUARD;
  localparam int ZW = WIDTH + 1;

  localparam logic signed [ZW-1:0]    PI_Z    = ZW'(PI);
  localparam logic signed [ZW-1:0]    NPI_Z   = -ZW'(PI);
  localparam logic signed [ZW-1:0]    HALF_Z  = ZW'(PI_HALF);
  localparam logic signed [ZW-1:0]    NHALF_Z = -ZW'(PI_HALF);
  localparam logic signed [XW-1:0]    X_INIT  = XW'(K_GAIN * (2 ** GUARD));
  localparam logic signed [WIDTH-1:0] MAX_W   = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [XW-1:0]    MAX_X   = XW'(MAX_W);
  localparam logic signed [XW-1:0]    MIN_X   = XW'(MIN_W);

  cordic_state_t         state_q;
  logic signed [XW-1:0]  x_q, y_q;
  logic signed [ZW-1:0]  z_q;
  logic [3:0]            iter_q;
  logic                  neg_q;
  logic                  oor_q;

  logic signed [ZW-1:0]  ang_z, clamp_z, z0;
  logic                  neg0, oor0;
  logic [ATAN_W-1:0]     atan_val;
  logic signed [ZW-1:0]  atan_z;
  logic signed [XW-1:0]  x_sh, y_sh, x_nx, y_nx;
  logic signed [ZW-1:0]  z_nx;

  cordic_atan_rom u_atan_rom (
    .idx  (iter_q),
    .atan (atan_val)
  );

  assign ang_z = ZW'($signed(angle_in));

  always_comb begin
    clamp_z = ang_z;
    z0      = ang_z;
    neg0    = 1'b0;
    oor0    = 1'b0;
`ifdef CORDIC_QUAD_EN
    if (ang_z > PI_Z) begin
      clamp_z = PI_Z;
      oor0    = 1'b1;
    end else if (ang_z < NPI_Z) begin
      clamp_z = NPI_Z;
      oor0    = 1'b1;
    end
    // Outer half-planes rotate by pi, which flips the sign of both results.
    if (clamp_z > HALF_Z) begin
      z0   = clamp_z - PI_Z;
      neg0 = 1'b1;
    end else if (clamp_z < NHALF_Z) begin
      z0   = clamp_z + PI_Z;
      neg0 = 1'b1;
    end else begin
      z0 = clamp_z;
    end
`else
    if (ang_z > HALF_Z) begin
      clamp_z = HALF_Z;
      oor0    = 1'b1;
    end else if (ang_z < NHALF_Z) begin
      clamp_z = NHALF_Z;
      oor0    = 1'b1;
    end
    z0 = clamp_z;
`endif
  end

  // Both updates use the pre-step x/y.
  always_comb begin
    atan_z = {{(ZW-ATAN_W){1'b0}}, atan_val};
    x_sh   = x_q >>> iter_q;
    y_sh   = y_q >>> iter_q;
    if (!z_q[ZW-1]) begin
      x_nx = x_q - y_sh;
      y_nx = y_q + x_sh;
      z_nx = z_q - atan_z;
    end else begin
      x_nx = x_q + y_sh;
      y_nx = y_q - x_sh;
      z_nx = z_q + atan_z;
    end
  end

  function automatic logic [WIDTH-1:0] format_result(input logic signed [XW-1:0] v,
                                                      input logic neg);
    logic signed [XW-1:0]    t;
    logic signed [WIDTH-1:0] s;
    t = v >>> GUARD;
    if (t > MAX_X)      s = MAX_W;
    else if (t < MIN_X) s = MIN_W;
    else                s = t[WIDTH-1:0];
    if (neg) s = (s == MIN_W) ? MAX_W : -s;
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cos_out   <= '0;
      sin_out   <= '0;
      out_oor   <= 1'b0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
      iter_q    <= '0;
      neg_q     <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            x_q      <= X_INIT;
            y_q      <= '0;
            z_q      <= z0;
            iter_q   <= '0;
            neg_q    <= neg0;
            oor_q    <= oor0;
            in_ready <= 1'b0;
            state_q  <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          if (iter_q == 4'(ITERATIONS)) begin
            cos_out   <= format_result(x_q, neg_q);
            sin_out   <= format_result(y_q, neg_q);
            out_oor   <= oor_q;
            out_valid <= 1'b1;
            state_q   <= ST_DONE;
          end else begin
            x_q    <= x_nx;
            y_q    <= y_nx;
            z_q    <= z_nx;
            iter_q <= iter_q + 4'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Scoreboard bench for cordic_sincos: trigonometric reference model, directed corner cases, random traffic.
module tb_cordic_sincos;

  localparam int ITER = 14;
  localparam int W    = 16;
  localparam int TOL  = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] angle_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] cos_out;
  logic [W-1:0] sin_out;
  logic         out_oor;

  always #5 clk = ~clk;

  cordic_sincos #(.ITERATIONS(ITER), .WIDTH(W), .GUARD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .angle_in  (angle_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cos_out   (cos_out),
    .sin_out   (sin_out),
    .out_oor   (out_oor)
  );

  typedef struct {
    int c;
    int s;
    int oor;
    int acc;
    int ang;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   n_in   = 0;
  int   n_out  = 0;
  bit   rnd_ready = 1'b0;
  bit   prev_ov   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, act, exp, tol, cyc);
    end
  endtask

  function automatic int rnd(input real v);
    return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
  endfunction

  // Reference: clamp to the legal range of this build, then ideal cos/sin of the angle in radians.
  function automatic void model(input int ang, output int c, output int s, output int oor);
    int   a;
    real  r;
    a   = ang;
    oor = 0;
`ifdef CORDIC_QUAD_EN
    if (a > 25736)       begin a = 25736;  oor = 1; end
    else if (a < -25736) begin a = -25736; oor = 1; end
`else
    if (a > 12868)       begin a = 12868;  oor = 1; end
    else if (a < -12868) begin a = -12868; oor = 1; end
`endif
    r = real'(a) / 8192.0;
    c = rnd(16384.0 * $cos(r));
    s = rnd(16384.0 * $sin(r));
  endfunction

  task automatic send(input int ang);
    exp_t e;
    int   waited;
    @(negedge clk);
    angle_in = ang[W-1:0];
    in_valid = 1'b1;
    waited   = 0;
    while (!in_ready && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1, 0);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    model(ang, e.c, e.s, e.oor);
    e.acc = cyc;
    e.ang = ang;
    sb.push_back(e);
    n_in++;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0 || out_valid) check("drain_timeout", sb.size(), 0, 0);
  endtask

  // Monitor: latency on the rising edge of out_valid, values on each output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (out_valid && !prev_ov) begin
        if (sb.size() == 0) check("unexpected_out", 1, 0, 0);
        else                check("latency", cyc - sb[0].acc, ITER + 1, 0);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("extra_result", 1, 0, 0);
        end else begin
          e = sb.pop_front();
          check($sformatf("cos(%0d)", e.ang), int'($signed(cos_out)), e.c, TOL);
          check($sformatf("sin(%0d)", e.ang), int'($signed(sin_out)), e.s, TOL);
          check($sformatf("oor(%0d)", e.ang), int'(out_oor), e.oor, 0);
          n_out++;
        end
      end
    end
    prev_ov = out_valid;
  end

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  int directed[8] = '{0, 4289, -12868, 25736, 32000, -25736, 12868, -32768};

  initial begin
    int cc, ss, oo, waited;
    rst       = 1'b1;
    in_valid  = 1'b0;
    angle_in  = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1, 0);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_cos", int'(cos_out), 0, 0);
    check("rst_sin", int'(sin_out), 0, 0);
    check("rst_oor", int'(out_oor), 0, 0);
    rst = 1'b0;

    foreach (directed[k]) begin
      send(directed[k]);
      drain();
    end

    // Consumer stalls for 5 cycles with a result pending.
    @(posedge clk); #1 out_ready = 1'b0;
    send(8000);
    waited = 0;
    while (!out_valid && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("stall_reach_done", int'(out_valid), 1, 0);
    cc = int'(cos_out); ss = int'(sin_out); oo = int'(out_oor);
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", int'(out_valid), 1, 0);
      check("stall_in_ready", int'(in_ready), 0, 0);
      check("stall_cos_hold", int'(cos_out), cc, 0);
      check("stall_sin_hold", int'(sin_out), ss, 0);
      check("stall_oor_hold", int'(out_oor), oo, 0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("post_hs_in_ready", int'(in_ready), 1, 0);
    check("post_hs_out_valid", int'(out_valid), 0, 0);
    send(-9000);
    drain();

    // A second angle offered while busy must be ignored.
    send(1000);
    @(negedge clk);
    angle_in = 16'(-5000);
    in_valid = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check("busy_in_ready", int'(in_ready), 0, 0);
    end
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a rotation abandons the operation.
    send(3000);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_in -= sb.size();
    sb.delete();
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 1, 0);
    check("midrst_out_valid", int'(out_valid), 0, 0);
    send(0);
    drain();

    // Random angles across the full input range with a bursty consumer.
    rnd_ready = 1'b1;
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] r;
      r = W'($urandom_range(0, 65535));
      send(int'($signed(r)));
    end
    drain();
    rnd_ready = 1'b0;
    @(posedge clk); #1 out_ready = 1'b1;

    check("result_count", n_out, n_in, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
